// File: rtl/slack_update.sv
// ADMM slack step: clamp(u+y) and clamp(x+g) per element, one element per lane per cycle.
// Latency: N cycles after the accept edge, then one DONE cycle; start is ignored while busy.
module slack_update #(
  parameter int STATE_DIM   = 6,
  parameter int CONTROL_DIM = 12,
  parameter int W           = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [STATE_DIM-1:0][W-1:0]     u_k,
  input  logic [STATE_DIM-1:0][W-1:0]     y_k,
  input  logic [CONTROL_DIM-1:0][W-1:0]   x_k,
  input  logic [CONTROL_DIM-1:0][W-1:0]   g_k,
  input  logic [W-1:0]                    u_min,
  input  logic [W-1:0]                    u_max,
  input  logic [W-1:0]                    x_min,
  input  logic [W-1:0]                    x_max,
  output logic [STATE_DIM-1:0][W-1:0]     z_out,
  output logic [CONTROL_DIM-1:0][W-1:0]   v_out,
  output logic                            busy,
  output logic                            done
);

  localparam int N  = (STATE_DIM > CONTROL_DIM) ? STATE_DIM : CONTROL_DIM;
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [IW-1:0]                   r_idx;
  logic [STATE_DIM-1:0][W-1:0]     r_u;
  logic [STATE_DIM-1:0][W-1:0]     r_y;
  logic [CONTROL_DIM-1:0][W-1:0]   r_x;
  logic [CONTROL_DIM-1:0][W-1:0]   r_g;
  logic [W-1:0]                    r_u_min;
  logic [W-1:0]                    r_u_max;
  logic [W-1:0]                    r_x_min;
  logic [W-1:0]                    r_x_max;
  logic [W-1:0]                    w_u_sel;
  logic [W-1:0]                    w_y_sel;
  logic [W-1:0]                    w_x_sel;
  logic [W-1:0]                    w_g_sel;
  logic [W-1:0]                    w_z_res;
  logic [W-1:0]                    w_v_res;
  logic                            w_accept;

  // One extra sum bit keeps the add from wrapping before the bound compare.
  function automatic logic [W-1:0] clamp_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] lo, input logic [W-1:0] hi);
    logic signed [W:0] sum;
    sum = $signed({a[W-1], a}) + $signed({b[W-1], b});
    if (sum < $signed({lo[W-1], lo}))      return lo;
    else if (sum > $signed({hi[W-1], hi})) return hi;
    else                                   return sum[W-1:0];
  endfunction

  always_comb begin
    w_u_sel = '0;
    w_y_sel = '0;
    w_x_sel = '0;
    w_g_sel = '0;
    for (int i = 0; i < STATE_DIM; i++) begin
      if (r_idx == IW'(i)) begin
        w_u_sel = r_u[i];
        w_y_sel = r_y[i];
      end
    end
    for (int i = 0; i < CONTROL_DIM; i++) begin
      if (r_idx == IW'(i)) begin
        w_x_sel = r_x[i];
        w_g_sel = r_g[i];
      end
    end
  end

  assign w_z_res  = clamp_add(w_u_sel, w_y_sel, r_u_min, r_u_max);
  assign w_v_res  = clamp_add(w_x_sel, w_g_sel, r_x_min, r_x_max);
  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_idx == LAST_IDX) w_next_state = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept)                r_idx <= '0;
      else if (r_state == S_RUN)   r_idx <= r_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_u     <= '0;
      r_y     <= '0;
      r_x     <= '0;
      r_g     <= '0;
      r_u_min <= '0;
      r_u_max <= '0;
      r_x_min <= '0;
      r_x_max <= '0;
    end else if (w_accept) begin
      r_u     <= u_k;
      r_y     <= y_k;
      r_x     <= x_k;
      r_g     <= g_k;
      r_u_min <= u_min;
      r_u_max <= u_max;
      r_x_min <= x_min;
      r_x_max <= x_max;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_out <= '0;
      v_out <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < STATE_DIM; i++) begin
        if (r_idx == IW'(i)) z_out[i] <= w_z_res;
      end
      for (int i = 0; i < CONTROL_DIM; i++) begin
        if (r_idx == IW'(i)) v_out[i] <= w_v_res;
      end
    end
  end

endmodule

// File: tb/tb_slack_update.sv
// Scoreboard bench for slack_update: expected vectors queued at start, compared on each done pulse.
module tb_slack_update;
  localparam int SD = 6;
  localparam int CD = 12;
  localparam int W  = 16;

  typedef struct packed {
    logic [SD-1:0][W-1:0] z;
    logic [CD-1:0][W-1:0] v;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [SD-1:0][W-1:0]  u_k;
  logic [SD-1:0][W-1:0]  y_k;
  logic [CD-1:0][W-1:0]  x_k;
  logic [CD-1:0][W-1:0]  g_k;
  logic [W-1:0]          u_min;
  logic [W-1:0]          u_max;
  logic [W-1:0]          x_min;
  logic [W-1:0]          x_max;
  logic [SD-1:0][W-1:0]  z_out;
  logic [CD-1:0][W-1:0]  v_out;
  logic                  busy;
  logic                  done;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks    = 0;
  int   errors    = 0;
  int   done_cnt  = 0;
  int   cyc       = 0;
  bit   b2b_mode  = 1'b0;

  slack_update #(.STATE_DIM(SD), .CONTROL_DIM(CD), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .u_k   (u_k),
    .y_k   (y_k),
    .x_k   (x_k),
    .g_k   (g_k),
    .u_min (u_min),
    .u_max (u_max),
    .x_min (x_min),
    .x_max (x_max),
    .z_out (z_out),
    .v_out (v_out),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_clamp(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] lo, input logic [W-1:0] hi);
    int s;
    int l;
    int h;
    s = int'($signed(a)) + int'($signed(b));
    l = int'($signed(lo));
    h = int'($signed(hi));
    if (s < l) return lo;
    if (s > h) return hi;
    return s[W-1:0];
  endfunction

  function automatic exp_t model();
    exp_t e;
    for (int i = 0; i < SD; i++) e.z[i] = ref_clamp(u_k[i], y_k[i], u_min, u_max);
    for (int i = 0; i < CD; i++) e.v[i] = ref_clamp(x_k[i], g_k[i], x_min, x_max);
    return e;
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < SD; i++) begin
      u_k[i] = W'($urandom);
      y_k[i] = W'($urandom);
    end
    for (int i = 0; i < CD; i++) begin
      x_k[i] = W'($urandom);
      g_k[i] = W'($urandom);
    end
    u_min = W'($urandom);
    u_max = W'($urandom);
    x_min = W'($urandom);
    x_max = W'($urandom);
  endtask

  // Called one tick after a rising edge with the DUT idle; returns one tick after the accept edge.
  task automatic do_start(input bit push);
    last_exp = model();
    if (push) sb_q.push_back(last_exp);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input string tag);
    int lat;
    do_start(1'b1);
    wait_done(lat);
    check({tag, "_lat"}, lat, 12);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    int   last_done;
    last_done = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset && done) begin
        done_cnt++;
        check("busy_at_done", busy, 1);
        if (sb_q.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          e = sb_q.pop_front();
          for (int i = 0; i < SD; i++) check($sformatf("z[%0d]", i), $signed(z_out[i]), $signed(e.z[i]));
          for (int i = 0; i < CD; i++) check($sformatf("v[%0d]", i), $signed(v_out[i]), $signed(e.v[i]));
        end
        if (b2b_mode) begin
          if (last_done >= 0) check("done_period", cyc - last_done, 14);
          last_done = cyc;
        end
      end
      if (!b2b_mode) last_done = -1;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   lat;
    int   base;
    exp_t prev;
    exp_t cur;
    reset = 1'b1;
    start = 1'b0;
    u_k = '0; y_k = '0; x_k = '0; g_k = '0;
    u_min = '0; u_max = '0; x_min = '0; x_max = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", |z_out, 0);
    check("rst_v", |v_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic ramp through both lanes
    for (int i = 0; i < SD; i++) begin u_k[i] = W'(i + 1); y_k[i] = '0; end
    for (int i = 0; i < CD; i++) begin x_k[i] = W'(i + 1); g_k[i] = '0; end
    u_min = W'(-4); u_max = W'(4); x_min = W'(0); x_max = W'(8);
    do_start(1'b1);
    wait_done(lat);
    check("basic_lat", lat, 12);
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_idle", busy, 0);
    check("basic_z2", $signed(z_out[2]), 3);
    check("basic_z5", $signed(z_out[5]), 4);
    check("basic_v7", $signed(v_out[7]), 8);
    check("basic_v11", $signed(v_out[11]), 8);
    @(posedge clk);
    #1;

    // Saturation at the word limits
    for (int i = 0; i < SD; i++) begin
      u_k[i] = (i < 3) ? 16'h7FFF : 16'h8000;
      y_k[i] = (i < 3) ? 16'h0001 : 16'hFFFF;
    end
    for (int i = 0; i < CD; i++) begin
      x_k[i] = (i < 6) ? 16'h7FFF : 16'h8000;
      g_k[i] = (i < 6) ? 16'h0001 : 16'hFFFF;
    end
    u_min = 16'h8000; u_max = 16'h7FFF; x_min = 16'h8000; x_max = 16'h7FFF;
    run("ovf");
    check("ovf_hi", $signed(z_out[0]), 32767);
    check("ovf_lo", $signed(z_out[5]), -32768);

    // Negative clamp and pass-through
    for (int i = 0; i < CD; i++) begin
      x_k[i] = (i % 2 == 0) ? W'(-10) : W'(2);
      g_k[i] = (i % 2 == 0) ? W'(3)   : W'(-1);
    end
    x_min = W'(-5); x_max = W'(5);
    run("neg");
    check("neg_v0", $signed(v_out[0]), -5);
    check("neg_v1", $signed(v_out[1]), 1);

    // Reset mid-run: check progressive update first, then abort
    prev = last_exp;
    for (int i = 0; i < CD; i++) begin x_k[i] = W'(100); g_k[i] = '0; end
    x_min = W'(-50); x_max = W'(50);
    base = done_cnt;
    do_start(1'b0);
    cur = last_exp;
    repeat (5) @(posedge clk);
    #1;
    check("prog_new_v4", $signed(v_out[4]), $signed(cur.v[4]));
    check("prog_old_v5", $signed(v_out[5]), $signed(prev.v[5]));
    reset = 1'b0;
    #1;
    check("abort_z", |z_out, 0);
    check("abort_v", |v_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - base, 0);
    run("post_rst");

    // Handshake: inputs and start toggled during RUN must not matter
    rand_inputs();
    base = done_cnt;
    do_start(1'b1);
    repeat (3) @(posedge clk);
    #1;
    rand_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rand_inputs();
    wait_done(lat);
    check("hs_lat", lat, 8);
    repeat (20) @(posedge clk);
    #1;
    check("hs_one_done", done_cnt - base, 1);

    // Back-to-back with start held high
    rand_inputs();
    base = done_cnt;
    b2b_mode = 1'b1;
    cur = model();
    repeat (3) sb_q.push_back(cur);
    start = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    b2b_mode = 1'b0;
    check("b2b_runs", done_cnt - base, 3);

    // Random data and bounds, including inverted bounds
    for (int r = 0; r < 4; r++) begin
      rand_inputs();
      run("rnd");
    end

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
